// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response port: in-order requests (req/ready), in-order responses (rvalid/rdata).
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch front end: in-order imem requests under a DEPTH credit limit, response buffer, redirect squash.
// rvalid->issue is 1 cycle, or 0 cycles on an empty buffer when IFETCH_FORWARD_EN is defined.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master imem,
  output logic                inst_v_o,
  output logic [31:0]         inst_o,
  output logic [31:0]         pc_o,
  input  logic                redir_v_i,
  input  logic [31:0]         redir_pc_i
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      inst_buf_q [DEPTH];
  logic [31:0]      pc_buf_q   [DEPTH];

  logic [CNT_W:0] credit_used;
  logic [31:0]    redir_pc;
  logic           accept, keep, fwd, push, pop;

  assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
  assign redir_pc       = {redir_pc_i[31:2], 2'b00};
  assign imem.imem_req  = !reset && !redir_v_i && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem.imem_addr = fetch_pc_q;
  assign accept         = imem.imem_req && imem.imem_ready;

  // Responses owed to a squashed path, or landing in a redirect cycle, never reach the buffer
  assign keep = imem.imem_rvalid && (discard_q == '0) && !redir_v_i && !reset;
`ifdef IFETCH_FORWARD_EN
  assign fwd  = keep && (count_q == '0);
`else
  assign fwd  = 1'b0;
`endif
  assign push = keep && !fwd;
  assign pop  = (count_q != '0) && !redir_v_i && !reset;

  assign inst_v_o = pop || fwd;
  assign inst_o   = fwd ? imem.imem_rdata : inst_buf_q[rd_ptr_q];
  assign pc_o     = fwd ? resp_pc_q : pc_buf_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = keep ? resp_pc_q + 32'd4 : resp_pc_q;
    outst_d    = outst_q + CNT_W'(accept) - CNT_W'(imem.imem_rvalid);
    discard_d  = discard_q;
    if (imem.imem_rvalid && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    if (redir_v_i) begin
      // Everything still in flight after this cycle belongs to the old path
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      discard_d  = outst_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_buf_q[wr_ptr_q] <= imem.imem_rdata;
      pc_buf_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (reset)
    imem.imem_rvalid |-> (outst_q != '0));
  credit_never_exceeded: assert property (@(posedge clk) disable iff (reset)
    credit_used <= (CNT_W+1)'(DEPTH));
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of fetch scenarios plus a mid-stream reset sequence.
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
`ifdef IFETCH_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  typedef struct {
    int          lat;
    int          stall_at;
    int          stall_len;
    int          redir_at;
    logic [31:0] redir_pc;
    bit          on_rvalid;
    int          run;
    int          exp_first;
    int          exp_max_outst;
    logic [31:0] exp_post_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_v_o;
  logic [31:0] inst_o, pc_o;
  logic        redir_v_i;
  logic [31:0] redir_pc_i;

  instruction_fetch_if imem();

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem       (imem),
    .inst_v_o   (inst_v_o),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .redir_v_i  (redir_v_i),
    .redir_pc_i (redir_pc_i)
  );

  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  // memory model state
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc;
  int          mem_lat;

  // monitor state
  logic [31:0] exp_pc, prev_addr, post_pc, first_pc;
  int          rel_cyc, first_v, issued, resp_n, max_outst;
  logic        prev_stall, after_redir, got_post;
  bit          chk_credit;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mem_loop();
    forever begin
      @(posedge clk);
      if (reset) begin
        mq_addr.delete();
        mq_due.delete();
      end else begin
        if (imem.imem_rvalid && mq_addr.size() != 0) begin
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end
        if (imem.imem_req && imem.imem_ready) begin
          mq_addr.push_back(imem.imem_addr);
          mq_due.push_back(cyc + mem_lat);
        end
      end
      cyc++;
      #1;
      if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = mq_addr[0] ^ KEY;
      end else begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
      end
    end
  endtask

  task automatic monitor_loop();
    int count_m;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_pc = RESET_PC; rel_cyc = 0; first_v = -1; issued = 0; resp_n = 0;
        max_outst = 0; prev_stall = 1'b0; after_redir = 1'b0; got_post = 1'b0;
        first_pc = 32'hFFFF_FFFF;
      end else begin
        rel_cyc++;
        count_m = resp_n - issued;
        if (mq_addr.size() > max_outst) max_outst = mq_addr.size();
        if (redir_v_i) begin
          chk("redir_inst_v", 32'(inst_v_o), 32'd0);
          chk("redir_req", 32'(imem.imem_req), 32'd0);
          exp_pc = {redir_pc_i[31:2], 2'b00};
          after_redir = 1'b1;
        end else begin
          if (prev_stall && imem.imem_req) chk("addr_hold", imem.imem_addr, prev_addr);
          if (chk_credit)
            chk("credit_req", 32'(imem.imem_req), 32'((mq_addr.size() + count_m) < DEPTH));
          if (inst_v_o) begin
            if (first_v < 0) begin
              first_v  = rel_cyc;
              first_pc = pc_o;
            end
            chk("issue_pc", pc_o, exp_pc);
            chk("issue_inst", inst_o, exp_pc ^ KEY);
            if (after_redir) begin
              post_pc     = pc_o;
              got_post    = 1'b1;
              after_redir = 1'b0;
            end
            exp_pc = exp_pc + 32'd4;
            issued++;
          end
        end
        prev_stall = imem.imem_req && !imem.imem_ready;
        prev_addr  = imem.imem_addr;
        if (imem.imem_rvalid) resp_n++;
      end
    end
  endtask

  // Leaves reset deasserted #2 after the last edge that samples it high.
  task automatic do_reset();
    reset           = 1'b1;
    redir_v_i       = 1'b0;
    imem.imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    bit fired;
    mem_lat    = v.lat;
    chk_credit = (v.redir_at < 0);
    do_reset();
    fired = 1'b0;
    for (int c = 1; c <= v.run; c++) begin
      if (v.stall_at >= 0 && c == v.stall_at + v.stall_len - 1)
        chk($sformatf("row%0d_stall_drained", idx), 32'(inst_v_o), 32'd0);
      imem.imem_ready = !(v.stall_at >= 0 && c >= v.stall_at && c < v.stall_at + v.stall_len);
      redir_v_i = 1'b0;
      if (v.redir_at >= 0 && !fired && c >= v.redir_at && (!v.on_rvalid || imem.imem_rvalid)) begin
        redir_v_i  = 1'b1;
        redir_pc_i = v.redir_pc;
        fired      = 1'b1;
      end
      @(posedge clk);
      #2;
    end
    redir_v_i = 1'b0;
    chk($sformatf("row%0d_first_valid_cycle", idx), 32'(first_v), 32'(v.exp_first));
    chk($sformatf("row%0d_progress", idx), 32'(issued > 10), 32'd1);
    if (v.exp_max_outst >= 0)
      chk($sformatf("row%0d_max_outstanding", idx), 32'(max_outst), 32'(v.exp_max_outst));
    if (v.redir_at >= 0) begin
      chk($sformatf("row%0d_redir_fired", idx), 32'(fired), 32'd1);
      chk($sformatf("row%0d_post_redir_pc", idx), got_post ? post_pc : 32'hFFFF_FFFF, v.exp_post_pc);
    end
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    cyc              = 0;
    mem_lat          = 1;
    chk_credit       = 1'b0;
    reset            = 1'b1;
    redir_v_i        = 1'b0;
    redir_pc_i       = 32'h0;
    imem.imem_ready  = 1'b1;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;

    //          lat stall len redir pc            onrv run first    maxo post_pc
    vecs[0] = '{1,  -1,   0,  -1,  32'h0000_0000, 0,   40, 3 - FWD, 1,  32'h0};
    vecs[1] = '{1,  10,   10, -1,  32'h0000_0000, 0,   50, 3 - FWD, 1,  32'h0};
    vecs[2] = '{6,  -1,   0,  -1,  32'h0000_0000, 0,   60, 8 - FWD, 4,  32'h0};
    vecs[3] = '{3,  -1,   0,  12,  32'h0000_0100, 0,   40, 5 - FWD, -1, 32'h0000_0100};
    vecs[4] = '{1,  -1,   0,  10,  32'h0000_0203, 1,   40, 3 - FWD, -1, 32'h0000_0200};

    fork
      mem_loop();
      monitor_loop();
    join_none

    repeat (2) @(posedge clk);
    #2;
    chk("reset_req", 32'(imem.imem_req), 32'd0);
    chk("reset_inst_v", 32'(inst_v_o), 32'd0);

    for (int i = 0; i < 5; i++) run_row(vecs[i], i);

    // Reset while requests are in flight: everything clears and fetch restarts at RESET_PC
    mem_lat    = 6;
    chk_credit = 1'b1;
    do_reset();
    repeat (10) begin
      @(posedge clk);
      #2;
    end
    chk("pre_reset_busy", 32'(mq_addr.size() >= 2), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_cycle_req", 32'(imem.imem_req), 32'd0);
    @(posedge clk);
    #2;
    chk("after_reset_inst_v", 32'(inst_v_o), 32'd0);
    chk("after_reset_req", 32'(imem.imem_req), 32'd0);
    reset = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #2;
    end
    chk("restart_first_valid_cycle", 32'(first_v), 32'(8 - FWD));
    chk("restart_pc", first_pc, RESET_PC);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
